// File: rtl/nand_scan_pipe.sv
// nand_scan_pipe: registers two operands (B captured inverted), forms the
// bitwise NAND in stage 1 and carries it through a DEPTH-stage pipeline with
// a per-stage valid bit and valid/ready handshaking on both ends.
// Optional build macro: SCAN_CHAIN_EN strings every data and valid flop into
// one mux-scan chain. Chain order from scan_in: v0, a[0..W-1], b[0..W-1],
// then v[k], data[k][0..W-1] for k = 1..DEPTH-1; scan_out is the MSB of the
// last stage. Without the macro, scan_en/scan_in are ignored and scan_out = 0.
module nand_scan_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in1,
    input  logic [WIDTH-1:0] in2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out,
    input  logic             scan_en,
    input  logic             scan_in,
    output logic             scan_out
);

    logic [DEPTH-1:0]              valid_q, valid_d;
    logic [WIDTH-1:0]              opA_q, opA_d;
    logic [WIDTH-1:0]              opB_q, opB_d;
    logic [DEPTH-1:1][WIDTH-1:0]   stageData_q, stageData_d;
    logic [DEPTH-1:0]              advance;
    logic                          shiftEn;

`ifdef SCAN_CHAIN_EN
    localparam int ChainLen = DEPTH + (DEPTH + 1) * WIDTH;

    logic [ChainLen-1:0] chain_q;
    logic [ChainLen-1:0] chain_d;

    assign shiftEn = scan_en;

    // Flatten all state flops into chain order (bit 0 sits next to scan_in)
    always_comb begin
        chain_q                   = '0;
        chain_q[0]                = valid_q[0];
        chain_q[WIDTH:1]          = opA_q;
        chain_q[2*WIDTH:WIDTH+1]  = opB_q;
        for (int k = 1; k < DEPTH; k++) begin
            chain_q[2*WIDTH + 1 + (k-1)*(WIDTH+1)]              = valid_q[k];
            chain_q[2*WIDTH + 2 + (k-1)*(WIDTH+1) +: WIDTH]     = stageData_q[k];
        end
    end

    assign chain_d  = {chain_q[ChainLen-2:0], scan_in};
    assign scan_out = chain_q[ChainLen-1];
`else
    logic unusedScan;

    assign shiftEn    = 1'b0;
    assign unusedScan = scan_en ^ scan_in;
    assign scan_out   = 1'b0;
`endif

    // A stage may load when it is empty or its contents move on this edge
    always_comb begin
        advance          = '0;
        advance[DEPTH-1] = !valid_q[DEPTH-1] | out_ready;
        for (int k = DEPTH - 2; k >= 0; k--) begin
            advance[k] = !valid_q[k] | advance[k+1];
        end
    end

    assign in_ready  = advance[0] & !shiftEn;
    assign out_valid = valid_q[DEPTH-1] & !shiftEn;
    assign out       = stageData_q[DEPTH-1];

    // Next state: functional pipeline advance, replaced by a chain shift in scan mode
    always_comb begin
        valid_d     = valid_q;
        opA_d       = opA_q;
        opB_d       = opB_q;
        stageData_d = stageData_q;

        if (advance[0]) begin
            valid_d[0] = in_valid;
            opA_d      = in1;
            opB_d      = ~in2;
        end
        if (advance[1]) begin
            valid_d[1]     = valid_q[0];
            stageData_d[1] = ~(opA_q & ~opB_q);
        end
        for (int k = 2; k < DEPTH; k++) begin
            if (advance[k]) begin
                valid_d[k]     = valid_q[k-1];
                stageData_d[k] = stageData_q[k-1];
            end
        end

`ifdef SCAN_CHAIN_EN
        if (shiftEn) begin
            valid_d[0] = chain_d[0];
            opA_d      = chain_d[WIDTH:1];
            opB_d      = chain_d[2*WIDTH:WIDTH+1];
            for (int k = 1; k < DEPTH; k++) begin
                valid_d[k]     = chain_d[2*WIDTH + 1 + (k-1)*(WIDTH+1)];
                stageData_d[k] = chain_d[2*WIDTH + 2 + (k-1)*(WIDTH+1) +: WIDTH];
            end
        end
`endif
    end

    // State registers, cleared immediately by the asynchronous reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            opA_q       <= '0;
            opB_q       <= '0;
            stageData_q <= '0;
        end else begin
            valid_q     <= valid_d;
            opA_q       <= opA_d;
            opB_q       <= opB_d;
            stageData_q <= stageData_d;
        end
    end

endmodule

// File: tb/tb_nand_scan_pipe.sv
// Self-checking bench for nand_scan_pipe (WIDTH=8, DEPTH=3). A FIFO model of
// results with acceptance timestamps predicts in_ready, out_valid and out on
// every cycle; directed sequences add hand-computed literal expectations.
module tb_nand_scan_pipe;

    localparam int WIDTH = 8;
    localparam int DEPTH = 3;
`ifdef SCAN_CHAIN_EN
    localparam bit SCAN = 1'b1;
`else
    localparam bit SCAN = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             inValid;
    logic             inReady;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic             outValid;
    logic             outReady;
    logic [WIDTH-1:0] dutOut;
    logic             scanEn;
    logic             scanIn;
    logic             scanOut;

    int testsRun    = 0;
    int testsFailed = 0;

    nand_scan_pipe #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (inValid),
        .in_ready  (inReady),
        .in1       (in1),
        .in2       (in2),
        .out_valid (outValid),
        .out_ready (outReady),
        .out       (dutOut),
        .scan_en   (scanEn),
        .scan_in   (scanIn),
        .scan_out  (scanOut)
    );

    // Free-running clock, 10 time-unit period
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison: counts every call, reports mismatches
    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Drive the functional handshake inputs
    task automatic applyStimulus(input logic valid, input logic [WIDTH-1:0] a,
                                 input logic [WIDTH-1:0] b, input logic ready);
        inValid  = valid;
        in1      = a;
        in2      = b;
        outReady = ready;
    endtask

    // Advance to just after the next rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference model: accepted results in order, with the edge count at acceptance
    logic [WIDTH-1:0] expQ[$];
    int               ageQ[$];
    int               cycle = 0;

    // The asynchronous reset empties the pipeline at once
    always @(negedge rst_n) begin
        expQ.delete();
        ageQ.delete();
    end

    // Per-cycle comparison at the falling edge, model update at the rising edge
    always begin : compareProc
        logic             takeIn;
        logic             takeOut;
        logic             scanAct;
        logic             expValid;
        logic             expReady;
        logic [WIDTH-1:0] newRes;
        @(negedge clk);
        takeIn  = 1'b0;
        takeOut = 1'b0;
        newRes  = '0;
        if (rst_n) begin
            scanAct  = SCAN && scanEn;
            expValid = !scanAct && (expQ.size() > 0) && ((cycle - ageQ[0]) >= DEPTH - 1);
            expReady = !scanAct && ((expQ.size() < DEPTH) || outReady);
            checkOutput("cyc in_ready", 32'(inReady), 32'(expReady));
            checkOutput("cyc out_valid", 32'(outValid), 32'(expValid));
            if (expValid) checkOutput("cyc out", 32'(dutOut), 32'(expQ[0]));
            takeIn  = inValid && expReady;
            takeOut = expValid && outReady;
            newRes  = ~(in1 & in2);
        end
        @(posedge clk);
        cycle++;
        if (takeOut) begin
            void'(expQ.pop_front());
            void'(ageQ.pop_front());
        end
        if (takeIn) begin
            expQ.push_back(newRes);
            ageQ.push_back(cycle);
        end
    end

    // Guard against a run that never ends
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected $finish");
        $fatal(1, "[TB] timeout");
    end

    // Directed scenarios
    initial begin
        logic [3:0] patBits;
        logic       expBit;
        patBits = 4'b1101;

        rst_n  = 1'b0;
        scanEn = 1'b0;
        scanIn = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        repeat (3) tick();
        checkOutput("reset out", 32'(dutOut), 32'h00);
        checkOutput("reset out_valid", 32'(outValid), 32'h0);
        checkOutput("reset in_ready", 32'(inReady), 32'h1);
        checkOutput("reset scan_out", 32'(scanOut), 32'h0);
        rst_n = 1'b1;

        // Single operation, two edges of latency after acceptance
        applyStimulus(1'b1, 8'hF0, 8'h3C, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("single early", 32'(outValid), 32'h0);
        tick();
        checkOutput("single valid", 32'(outValid), 32'h1);
        checkOutput("single out", 32'(dutOut), 32'hCF);
        tick();
        checkOutput("single drop", 32'(outValid), 32'h0);

        // Back-to-back streaming
        applyStimulus(1'b1, 8'hFF, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h00, 8'hAA, 1'b1);
        tick();
        applyStimulus(1'b1, 8'h0F, 8'hF0, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("stream r0 valid", 32'(outValid), 32'h1);
        checkOutput("stream r0", 32'(dutOut), 32'h00);
        tick();
        checkOutput("stream r1", 32'(dutOut), 32'hFF);
        tick();
        checkOutput("stream r2", 32'(dutOut), 32'hFF);
        checkOutput("stream r2 valid", 32'(outValid), 32'h1);
        tick();
        checkOutput("stream end", 32'(outValid), 32'h0);

        // Backpressure: three fill the pipe, the fourth waits
        applyStimulus(1'b1, 8'h12, 8'h34, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hAA, 8'h55, 1'b0);
        tick();
        applyStimulus(1'b1, 8'hC3, 8'h81, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h77, 8'hEE, 1'b0);
        #1;
        checkOutput("bp full in_ready", 32'(inReady), 32'h0);
        tick();
        tick();
        checkOutput("bp stalled valid", 32'(outValid), 32'h1);
        checkOutput("bp stalled out", 32'(dutOut), 32'hEF);
        applyStimulus(1'b1, 8'h77, 8'hEE, 1'b1);
        #1;
        checkOutput("bp release in_ready", 32'(inReady), 32'h1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("bp r1", 32'(dutOut), 32'hFF);
        tick();
        checkOutput("bp r2", 32'(dutOut), 32'h7E);
        tick();
        checkOutput("bp r3", 32'(dutOut), 32'h99);
        tick();
        checkOutput("bp empty", 32'(outValid), 32'h0);

`ifdef SCAN_CHAIN_EN
        // Scan shift of a 1011 pattern through the 35-bit chain
        rst_n = 1'b0;
        #1;
        rst_n = 1'b1;
        scanEn = 1'b1;
        for (int n = 1; n <= 43; n++) begin
            scanIn = patBits[(n - 1) % 4];
            tick();
            expBit = (n >= 35) ? patBits[(n - 35) % 4] : 1'b0;
            checkOutput("scan_out shift", 32'(scanOut), 32'(expBit));
        end
        checkOutput("scan in_ready", 32'(inReady), 32'h0);
        checkOutput("scan out_valid", 32'(outValid), 32'h0);
        scanEn = 1'b0;
        rst_n  = 1'b0;
        tick();
        rst_n = 1'b1;
`else
        // Scan inputs have no effect in this build
        scanEn = 1'b1;
        scanIn = 1'b1;
        applyStimulus(1'b1, 8'h3C, 8'h0F, 1'b1);
        tick();
        scanIn = 1'b0;
        applyStimulus(1'b0, '0, '0, 1'b1);
        checkOutput("noscan scan_out", 32'(scanOut), 32'h0);
        tick();
        tick();
        checkOutput("noscan valid", 32'(outValid), 32'h1);
        checkOutput("noscan out", 32'(dutOut), 32'hF3);
        checkOutput("noscan scan_out late", 32'(scanOut), 32'h0);
        tick();
        scanEn = 1'b0;
`endif

        // Asynchronous reset with a full pipe
        applyStimulus(1'b1, 8'h01, 8'h01, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h02, 8'h03, 1'b0);
        tick();
        applyStimulus(1'b1, 8'h04, 8'h0C, 1'b0);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b0);
        checkOutput("arst full valid", 32'(outValid), 32'h1);
        checkOutput("arst full out", 32'(dutOut), 32'hFE);
        rst_n = 1'b0;
        #1;
        checkOutput("arst out_valid", 32'(outValid), 32'h0);
        checkOutput("arst out", 32'(dutOut), 32'h00);
        checkOutput("arst in_ready", 32'(inReady), 32'h1);
        #1;
        rst_n = 1'b1;
        applyStimulus(1'b1, 8'h5A, 8'hFF, 1'b1);
        tick();
        applyStimulus(1'b0, '0, '0, 1'b1);
        tick();
        checkOutput("arst next early", 32'(outValid), 32'h0);
        tick();
        checkOutput("arst next valid", 32'(outValid), 32'h1);
        checkOutput("arst next out", 32'(dutOut), 32'hA5);
        tick();
        tick();

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/nand_scan_pipe.md
# nand_scan_pipe

- Parametrised successor to the two-flop NAND capture cell: registers two WIDTH-bit operands, computes the bitwise NAND, and delays the result through a DEPTH-stage register pipeline.
- Each stage carries its own valid bit, and the pipeline has a valid/ready handshake on both ends.
- All flops can be strung into a single mux-scan chain for DFT.
- Sits between the input capture registers and downstream consumers in the timing-study datapath.

## Interface
- WIDTH, 8, operand/result bit width (≥1)
- DEPTH, 3, total register stages including capture stage (≥2)
- clk  input  1  single clock, rising edge
- rst_n  input  1  asynchronous, active-low reset
- in_valid  input  1  operand pair offered
- in_ready  output  1  pipeline can accept this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- out_valid  output  1  result present on out
- out_ready  input  1  consumer takes result this cycle
- out  output  WIDTH  result, ~(in1 & in2)
- scan_en  input  1  1 = shift mode, 0 = functional mode
- scan_in  input  1  scan chain serial input
- scan_out  output  1  scan chain serial output

## Operation
- Stage 0 captures a = in1 and b = ~in2 (inverted capture, as in the predecessor cell) plus v0.
- Stage 1 data = ~(a & ~b), i.e. ~(in1 & in2).
- Stages 2..DEPTH-1 copy the previous stage's data and valid. out = data of stage DEPTH-1; out_valid = v[DEPTH-1].
- Per-stage advance rule:
  - Last stage: adv[DEPTH-1] = !v[DEPTH-1] | out_ready.
  - Any other stage k: adv[k] = !v[k] | adv[k+1].
  - Bubbles collapse; no entry is ever overwritten or duplicated.
- in_ready = adv[0] & !scan_en. Transfer happens when in_valid & in_ready at a rising edge.
- A stage with adv=1 loads the upstream data and valid. Data of an invalid stage is don't-care but still clocked. Order is strictly FIFO.
- Scan mode (scan_en=1):
  - Every data and valid flop shifts one position per clock; handshake is frozen.
  - in_ready=0 and out_valid=0; out holds its register value.
  - Chain order from scan_in: v0, a[0..W-1], b[0..W-1], v1, stage1 data[0..W-1], …, v[DEPTH-1], stage DEPTH-1 data[0..W-1].
  - scan_out = data[W-1] of the last stage.
  - Chain length L = DEPTH + (DEPTH+1)·WIDTH.
- When scan_en falls, the pipeline resumes from whatever the chain holds, with valids taken at face value.
- Reset values: all v = 0, all data = 0, so out = 0, out_valid = 0, in_ready = 1 (scan_en=0), scan_out = 0.

## Timing
- Latency: transfer at edge E gives out_valid=1 after edge E+DEPTH-1 when unstalled (DEPTH=3: two edges after acceptance).
- Throughput: 1 per cycle with out_ready held high.
- Capacity: DEPTH entries. With out_ready=0, in_ready drops the cycle after all v are set.
- in_ready depends combinationally on out_ready through the adv chain; out, out_valid and scan_out are registered.
- If out_ready is high on the same edge as a new transfer and the pipe is full, both complete and occupancy is unchanged.
- rst_n asserted mid-stream clears all entries immediately, independent of clk. First acceptance is possible at the first edge after deassertion.
- scan_en is sampled at the edge. A transfer is never accepted on an edge where scan_en=1.

## Configuration
- SCAN_CHAIN_EN defined: scan mux and chain are present as described above.
- SCAN_CHAIN_EN undefined:
  - scan_en and scan_in are ignored and always treated as functional mode.
  - scan_out is tied to 0.
  - No scan muxes are generated.
- Ports exist in both builds.

## Test plan
Parameters for all scenarios: WIDTH=8, DEPTH=3.
- Reset: rst_n=0 with clock running → out=0x00, out_valid=0, in_ready=1, scan_out=0.
- Single op: in1=0xF0, in2=0x3C for one transfer, out_ready=1 → out_valid=1 with out=0xCF two edges later, then 0.
- Streaming: pairs (0xFF,0xFF), (0x00,0xAA), (0x0F,0xF0) back-to-back, out_ready=1 → results 0x00, 0xFF, 0xFF on consecutive cycles.
- Backpressure: out_ready=0, offer 4 ops → 3 accepted and in_ready=0. Raise out_ready → the 3 results emerge in order, then the 4th is accepted; none lost or duplicated.
- Scan (SCAN_CHAIN_EN): scan_en=1, shift 35 bits of pattern 1011… → pattern appears on scan_out starting at edge 35. in_ready=0 and out_valid=0 throughout. Without the macro, scan_out stays 0 and functional behaviour is unaffected.
- Async reset mid-stream: full pipe, pulse rst_n low between edges → out_valid and out go to 0 immediately, and next operand latency is 2 edges.
